// File: rtl/game_pkg.sv
// Shared game definitions: fireball state encoding, screen bounds and default frame/damage constants.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLIGHT,
    ST_IMPACT,
    ST_COOLDOWN
  } fireball_state_t;

  localparam int unsigned SCREEN_X_MIN        = 0;
  localparam int unsigned SCREEN_X_MAX        = 639;
  localparam int unsigned DEF_HIT_DAMAGE      = 10;
  localparam int unsigned DEF_IMPACT_FRAMES   = 8;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 120;

  // Signed width for position sums; wide enough that 1023 + offset cannot wrap.
  localparam int unsigned POS_W = 12;

  function automatic logic signed [POS_W-1:0] clamp_x(
    input logic signed [POS_W-1:0] x,
    input logic signed [POS_W-1:0] lo,
    input logic signed [POS_W-1:0] hi
  );
    if (x < lo)      return lo;
    else if (x > hi) return hi;
    else             return x;
  endfunction

endpackage

// File: rtl/hitbox_check.sv
// Combinational overlap test: hit when both absolute distances are below the half-extents.
module hitbox_check (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  logic [9:0] half_w,
  input  logic [9:0] half_h,
  output logic       hit
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic        [10:0] adx;
  logic        [10:0] ady;

  always_comb begin
    dx  = $signed({1'b0, ball_x}) - $signed({1'b0, target_x});
    dy  = $signed({1'b0, ball_y}) - $signed({1'b0, target_y});
    adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    hit = (adx < {1'b0, half_w}) && (ady < {1'b0, half_h});
  end

endmodule

// File: rtl/fireball_ctrl.sv
// Projectile engine: spawn, horizontal flight, hit detection, impact and cooldown.
// Optional FIREBALL_TRACK_EN: ball_y steps one pixel per frame toward target_y during flight.
module fireball_ctrl
  import game_pkg::*;
#(
  parameter int unsigned BALL_SPEED      = 6,
  parameter int unsigned SPAWN_DX        = 32,
  parameter int unsigned HIT_W           = 40,
  parameter int unsigned HIT_H           = 80,
  parameter int unsigned HIT_DAMAGE      = DEF_HIT_DAMAGE,
  parameter int unsigned IMPACT_FRAMES   = DEF_IMPACT_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int unsigned X_MIN           = SCREEN_X_MIN,
  parameter int unsigned X_MAX           = SCREEN_X_MAX
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       ending,
  input  logic       summon_ball,
  input  logic       face,
  input  logic [9:0] owner_x,
  input  logic [9:0] owner_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic       ball_ready,
  output logic       ball_active,
  output logic       ball_hit,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_face,
  output logic [9:0] damage
);

  localparam logic signed [POS_W-1:0] SPAWN_S = POS_W'(SPAWN_DX);
  localparam logic signed [POS_W-1:0] SPEED_S = POS_W'(BALL_SPEED);
  localparam logic signed [POS_W-1:0] XMIN_S  = POS_W'(X_MIN);
  localparam logic signed [POS_W-1:0] XMAX_S  = POS_W'(X_MAX);
  localparam logic [15:0] IMPACT_LAST   = 16'(IMPACT_FRAMES - 1);
  localparam logic [15:0] COOLDOWN_LAST = 16'(COOLDOWN_FRAMES - 1);

  fireball_state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [9:0]  x_nxt, y_nxt, dmg_nxt;
  logic        face_nxt, ready_nxt, active_nxt, hit_nxt;
  logic        overlap;
  logic signed [POS_W-1:0] owner_s, spawn_s, step_s;

  hitbox_check u_hitbox (
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .target_x (target_x),
    .target_y (target_y),
    .half_w   (10'(HIT_W / 2)),
    .half_h   (10'(HIT_H / 2)),
    .hit      (overlap)
  );

  always_comb begin
    owner_s = $signed({{(POS_W-10){1'b0}}, owner_x});
    spawn_s = face ? clamp_x(owner_s - SPAWN_S, XMIN_S, XMAX_S)
                   : clamp_x(owner_s + SPAWN_S, XMIN_S, XMAX_S);
    step_s  = ball_face ? $signed({{(POS_W-10){1'b0}}, ball_x}) - SPEED_S
                        : $signed({{(POS_W-10){1'b0}}, ball_x}) + SPEED_S;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = ball_x;
    y_nxt     = ball_y;
    face_nxt  = ball_face;
    dmg_nxt   = '0;

    unique case (state)
      ST_IDLE: begin
        if (summon_ball) begin
          state_nxt = ST_FLIGHT;
          cnt_nxt   = '0;
          face_nxt  = face;
          y_nxt     = owner_y;
          x_nxt     = spawn_s[9:0];
        end
      end
      ST_FLIGHT: begin
        // Hit test uses the current (pre-move) position, so a hit beats out-of-bounds.
        if (overlap) begin
          state_nxt = ST_IMPACT;
          cnt_nxt   = '0;
          dmg_nxt   = 10'(HIT_DAMAGE);
        end else if (step_s < XMIN_S || step_s > XMAX_S) begin
          state_nxt = ST_COOLDOWN;
          cnt_nxt   = '0;
        end else begin
          x_nxt = step_s[9:0];
`ifdef FIREBALL_TRACK_EN
          if (ball_y < target_y)      y_nxt = ball_y + 10'd1;
          else if (ball_y > target_y) y_nxt = ball_y - 10'd1;
`endif
        end
      end
      ST_IMPACT: begin
        if (cnt == IMPACT_LAST) begin
          state_nxt = ST_COOLDOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_COOLDOWN: begin
        if (cnt == COOLDOWN_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (!ending) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      dmg_nxt   = '0;
    end

    ready_nxt  = (state_nxt == ST_IDLE) && ending;
    active_nxt = (state_nxt == ST_FLIGHT) || (state_nxt == ST_IMPACT);
    hit_nxt    = (state_nxt == ST_IMPACT);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ball_ready  <= 1'b0;
      ball_active <= 1'b0;
      ball_hit    <= 1'b0;
      ball_x      <= '0;
      ball_y      <= '0;
      ball_face   <= 1'b0;
      damage      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ball_ready  <= ready_nxt;
      ball_active <= active_nxt;
      ball_hit    <= hit_nxt;
      ball_x      <= x_nxt;
      ball_y      <= y_nxt;
      ball_face   <= face_nxt;
      damage      <= dmg_nxt;
    end
  end

endmodule

// File: tb/tb_fireball_ctrl.sv
// Directed self-checking bench for fireball_ctrl with hand-computed frame-by-frame expectations.
module tb_fireball_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset, ending, summon_ball, face;
  logic [9:0] owner_x, owner_y, target_x, target_y;
  logic       ball_ready, ball_active, ball_hit, ball_face;
  logic [9:0] ball_x, ball_y, damage;

  int n_checks = 0;
  int n_fail   = 0;

  fireball_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .ending      (ending),
    .summon_ball (summon_ball),
    .face        (face),
    .owner_x     (owner_x),
    .owner_y     (owner_y),
    .target_x    (target_x),
    .target_y    (target_y),
    .ball_ready  (ball_ready),
    .ball_active (ball_active),
    .ball_hit    (ball_hit),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_face   (ball_face),
    .damage      (damage)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  initial begin
    Reset = 1'b1; ending = 1'b0; summon_ball = 1'b0; face = 1'b0;
    owner_x = '0; owner_y = '0; target_x = '0; target_y = '0;
    step(2);
    check("rst_ready",  int'(ball_ready),  0);
    check("rst_active", int'(ball_active), 0);
    check("rst_hit",    int'(ball_hit),    0);
    check("rst_x",      int'(ball_x),      0);
    check("rst_y",      int'(ball_y),      0);
    check("rst_face",   int'(ball_face),   0);
    check("rst_damage", int'(damage),      0);

    Reset = 1'b0; ending = 1'b1;
    step(1);
    check("idle_ready", int'(ball_ready), 1);

    // Leftward shot from 480 into a target at 200: hit at x=214, 40 frames after summon.
    owner_x = 10'd480; owner_y = 10'd300; face = 1'b1;
    target_x = 10'd200; target_y = 10'd300;
    summon_ball = 1'b1;
    step(1);
    summon_ball = 1'b0;
    check("t1_spawn_x", int'(ball_x),      448);
    check("t1_ready0",  int'(ball_ready),  0);
    check("t1_active",  int'(ball_active), 1);
    check("t1_face",    int'(ball_face),   1);
    check("t1_y",       int'(ball_y),      300);
    step(1);
    check("t1_move1",   int'(ball_x), 442);
    step(38);
    check("t1_x39",     int'(ball_x), 214);
    check("t1_dmg39",   int'(damage), 0);
    check("t1_hit39",   int'(ball_hit), 0);
    step(1);
    check("t1_dmg40",   int'(damage), 10);
    check("t1_hit40",   int'(ball_hit), 1);
    check("t1_x40",     int'(ball_x), 214);
    check("t1_y40",     int'(ball_y), 300);
    step(1);
    check("t1_dmg41",   int'(damage), 0);
    check("t1_hit41",   int'(ball_hit), 1);
    check("t1_x41",     int'(ball_x), 214);
    step(6);
    check("t1_hit47",   int'(ball_hit), 1);
    check("t1_act47",   int'(ball_active), 1);
    step(1);
    check("t1_hit48",   int'(ball_hit), 0);
    check("t1_act48",   int'(ball_active), 0);
    check("t1_rdy48",   int'(ball_ready), 0);
    step(119);
    check("t1_rdy167",  int'(ball_ready), 0);
    step(1);
    check("t1_rdy168",  int'(ball_ready), 1);

    // Rightward shot near the right edge: out of bounds, no damage; summon spam in cooldown.
    owner_x = 10'd600; face = 1'b0; target_x = 10'd100;
    summon_ball = 1'b1;
    step(1);
    summon_ball = 1'b0;
    check("t2_spawn_x", int'(ball_x), 632);
    check("t2_face",    int'(ball_face), 0);
    step(1);
    check("t2_x1",      int'(ball_x), 638);
    check("t2_act1",    int'(ball_active), 1);
    step(1);
    check("t2_act2",    int'(ball_active), 0);
    check("t2_x2",      int'(ball_x), 638);
    check("t2_dmg2",    int'(damage), 0);
    summon_ball = 1'b1;
    step(119);
    check("t2_rdy121",  int'(ball_ready), 0);
    check("t2_act121",  int'(ball_active), 0);
    check("t2_x121",    int'(ball_x), 638);
    summon_ball = 1'b0;
    step(1);
    check("t2_rdy122",  int'(ball_ready), 1);

    // Summon held through flight: no respawn, no jump.
    owner_x = 10'd300; owner_y = 10'd100; face = 1'b0;
    target_x = 10'd600; target_y = 10'd400;
    summon_ball = 1'b1;
    step(1);
    check("t3_spawn_x", int'(ball_x), 332);
    owner_x = 10'd50;
    step(5);
    check("t3_x5",      int'(ball_x), 362);
    check("t3_act5",    int'(ball_active), 1);
    check("t3_y5",      int'(ball_y), 100);
    summon_ball = 1'b0;

    // ending dropped mid-flight.
    ending = 1'b0;
    step(1);
    check("t4_act",     int'(ball_active), 0);
    check("t4_rdy",     int'(ball_ready), 0);
    check("t4_dmg",     int'(damage), 0);
    step(1);
    check("t4_rdy2",    int'(ball_ready), 0);
    ending = 1'b1;
    step(1);
    check("t4_rdy_back", int'(ball_ready), 1);

    // Spawn clamp at the left edge, then immediate out-of-bounds without wrap.
    owner_x = 10'd10; face = 1'b1;
    summon_ball = 1'b1;
    step(1);
    summon_ball = 1'b0;
    check("t5_spawn_x", int'(ball_x), 0);
    check("t5_act0",    int'(ball_active), 1);
    step(1);
    check("t5_x1",      int'(ball_x), 0);
    check("t5_act1",    int'(ball_active), 0);
    check("t5_rdy1",    int'(ball_ready), 0);
    // Reset aborts the cooldown.
    Reset = 1'b1;
    step(1);
    check("t5_rst_rdy", int'(ball_ready), 0);
    check("t5_rst_face", int'(ball_face), 0);
    Reset = 1'b0;
    step(1);
    check("t5_rdy_post", int'(ball_ready), 1);

    // Vertical behaviour during flight toward an offset target.
    owner_x = 10'd100; owner_y = 10'd300; face = 1'b0;
    target_x = 10'd600; target_y = 10'd310;
    summon_ball = 1'b1;
    step(1);
    summon_ball = 1'b0;
    check("t6_y0", int'(ball_y), 300);
    step(5);
`ifdef FIREBALL_TRACK_EN
    check("t6_y5", int'(ball_y), 305);
`else
    check("t6_y5", int'(ball_y), 300);
`endif
    step(7);
`ifdef FIREBALL_TRACK_EN
    check("t6_y12", int'(ball_y), 310);
`else
    check("t6_y12", int'(ball_y), 300);
`endif
    check("t6_x12", int'(ball_x), 204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
